// File: rtl/points_uart_tx.sv
// points_uart_tx: serialises the four tracker centroid pairs as one 8N1 UART packet per video frame.
// Define POINTS_TX_CHECKSUM_EN to append a modulo-256 checksum byte (sum of bytes 1..17).
module points_uart_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        VGA_VS,
  input  logic        ENABLE,
  input  logic [15:0] POINTS_H_0,
  input  logic [15:0] POINTS_H_1,
  input  logic [15:0] POINTS_H_2,
  input  logic [15:0] POINTS_H_3,
  input  logic [15:0] POINTS_V_0,
  input  logic [15:0] POINTS_V_1,
  input  logic [15:0] POINTS_V_2,
  input  logic [15:0] POINTS_V_3,
  output logic        UART_TX,
  output logic        BUSY,
  output logic [7:0]  FRAME_ID,
  output logic [7:0]  DROP_CNT
);

  localparam int unsigned   CLKS_PER_BIT = int'(CLK_FREQ / BAUD);
  localparam int unsigned   BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST    = BW'(CLKS_PER_BIT - 1);
`ifdef POINTS_TX_CHECKSUM_EN
  localparam logic [4:0]    LAST_IDX     = 5'd18;
`else
  localparam logic [4:0]    LAST_IDX     = 5'd17;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  logic          r_vs;
  logic          r_tx;
  logic          r_busy;
  logic [7:0]    r_frame_id;
  logic [7:0]    r_drop;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [4:0]    r_idx;
  logic [7:0]    r_shift;
  logic [15:0]   r_shadow [8];
`ifdef POINTS_TX_CHECKSUM_EN
  logic [7:0]    r_csum;
`endif

  logic        w_edge;
  logic        w_bit_end;
  logic [4:0]  w_next_idx;
  logic [3:0]  w_off;
  logic [15:0] w_word;
  logic [7:0]  w_next_byte;

  assign w_edge     = VGA_VS & ~r_vs;
  assign w_bit_end  = (r_baud == BAUD_LAST);
  assign w_next_idx = r_idx + 5'd1;
  // Bytes 2..17 walk the shadow words MSB first; the low 4 bits of (idx-2) suffice.
  assign w_off      = w_next_idx[3:0] - 4'd2;
  assign w_word     = r_shadow[w_off[3:1]];

  always_comb begin
    w_next_byte = '0;
    if (w_next_idx == 5'd1)
      w_next_byte = r_frame_id;
    else if (w_next_idx >= 5'd2 && w_next_idx <= 5'd17)
      w_next_byte = w_off[0] ? w_word[7:0] : w_word[15:8];
`ifdef POINTS_TX_CHECKSUM_EN
    else
      w_next_byte = r_csum;
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_vs       <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_frame_id <= '0;
      r_drop     <= '0;
      r_baud     <= '0;
      r_bit      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      for (int unsigned i = 0; i < 8; i++) r_shadow[i] <= '0;
`ifdef POINTS_TX_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_vs <= VGA_VS;
      if (w_edge && ENABLE && r_busy && r_drop != 8'hFF)
        r_drop <= r_drop + 8'd1;

      case (r_state)
        S_IDLE: begin
          if (w_edge && ENABLE && !r_busy)
            r_state <= S_LOAD;
        end
        S_LOAD: begin
          // Sampled one cycle after the VS edge so the freshly updated points are taken.
          r_shadow[0] <= POINTS_H_0;
          r_shadow[1] <= POINTS_V_0;
          r_shadow[2] <= POINTS_H_1;
          r_shadow[3] <= POINTS_V_1;
          r_shadow[4] <= POINTS_H_2;
          r_shadow[5] <= POINTS_V_2;
          r_shadow[6] <= POINTS_H_3;
          r_shadow[7] <= POINTS_V_3;
          r_frame_id  <= r_frame_id + 8'd1;
          r_busy      <= 1'b1;
          r_tx        <= 1'b0;
          r_shift     <= 8'hA5;
          r_idx       <= '0;
          r_baud      <= '0;
`ifdef POINTS_TX_CHECKSUM_EN
          r_csum      <= '0;
`endif
          r_state     <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_idx == LAST_IDX) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= w_next_idx;
              r_shift <= w_next_byte;
              r_tx    <= 1'b0;
`ifdef POINTS_TX_CHECKSUM_EN
              r_csum  <= r_csum + w_next_byte;
`endif
              r_state <= S_START;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign UART_TX  = r_tx;
  assign BUSY     = r_busy;
  assign FRAME_ID = r_frame_id;
  assign DROP_CNT = r_drop;

endmodule

// File: tb/tb_points_uart_tx.sv
// Self-checking bench for points_uart_tx: table-driven packets plus overrun, enable, reset and FRAME_ID wrap sequences.
module tb_points_uart_tx;
`ifdef POINTS_TX_CHECKSUM_EN
  localparam int NBYTES = 19;
`else
  localparam int NBYTES = 18;
`endif

  typedef logic [7:0][15:0] pts_t;
  typedef struct {
    pts_t       p;
    logic [7:0] csum;
  } vec_t;

  logic       clk = 1'b0, rst_n = 1'b1, vs = 1'b0, en = 1'b0;
  pts_t       pts = '0;
  logic       tx, busy;
  logic [7:0] fid, drop;

  logic       fclk = 1'b0, frst_n = 1'b1, fvs = 1'b0;
  pts_t       wpts = '0;
  logic       ftx, fbusy;
  logic [7:0] ffid, fdrop;

  int total = 0, bad = 0;
  int cyc = 0;
  int txlow = 0, busy_run = 0, busy_len = 0, rx_ferr = 0;
  logic [7:0] rxq[$];
  int rxt[$];

  always #5 clk = ~clk;
  always #1 fclk = ~fclk;
  always @(posedge clk) cyc <= cyc + 1;

  points_uart_tx #(.CLK_FREQ(1000), .BAUD(100)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .VGA_VS(vs), .ENABLE(en),
    .POINTS_H_0(pts[0]), .POINTS_V_0(pts[1]), .POINTS_H_1(pts[2]), .POINTS_V_1(pts[3]),
    .POINTS_H_2(pts[4]), .POINTS_V_2(pts[5]), .POINTS_H_3(pts[6]), .POINTS_V_3(pts[7]),
    .UART_TX(tx), .BUSY(busy), .FRAME_ID(fid), .DROP_CNT(drop)
  );

  points_uart_tx #(.CLK_FREQ(2), .BAUD(1)) u_wrap (
    .CLK(fclk), .RESET_N(frst_n), .VGA_VS(fvs), .ENABLE(1'b1),
    .POINTS_H_0(wpts[0]), .POINTS_V_0(wpts[1]), .POINTS_H_1(wpts[2]), .POINTS_V_1(wpts[3]),
    .POINTS_H_2(wpts[4]), .POINTS_V_2(wpts[5]), .POINTS_H_3(wpts[6]), .POINTS_V_3(wpts[7]),
    .UART_TX(ftx), .BUSY(fbusy), .FRAME_ID(ffid), .DROP_CNT(fdrop)
  );

  always @(negedge clk) begin
    if (tx == 1'b0) txlow <= txlow + 1;
    if (busy) busy_run <= busy_run + 1;
    else begin
      if (busy_run != 0) busy_len <= busy_run;
      busy_run <= 0;
    end
  end

  // Line receiver: start seen at bit offset 0, each bit sampled mid-way (offset 10*j+5).
  initial begin : rx
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        t0 = cyc;
        b  = '0;
        repeat (5) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (10) @(negedge clk);
          b[j] = tx;
        end
        repeat (10) @(negedge clk);
        if (tx !== 1'b1) rx_ferr++;
        rxq.push_back(b);
        rxt.push_back(t0);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic vs_rise(output int n);
    @(posedge clk); #1;
    vs = 1'b1;
    n  = cyc;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 4000);
    check({name, " busy_timeout"}, busy, 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_pkt(input string name, input pts_t p, input logic [7:0] fexp,
                           input logic [7:0] cexp, input int nvs);
    logic [7:0] e [19];
    e[0] = 8'hA5;
    e[1] = fexp;
    for (int i = 0; i < 8; i++) begin
      e[2 + 2 * i] = p[i][15:8];
      e[3 + 2 * i] = p[i][7:0];
    end
    e[18] = cexp;
    check({name, " nbytes"}, rxq.size(), NBYTES);
    for (int i = 0; i < NBYTES && i < rxq.size(); i++) begin
      check($sformatf("%s byte%0d", name, i), rxq[i], e[i]);
      check($sformatf("%s start%0d", name, i), rxt[i], nvs + 2 + 100 * i);
    end
    check({name, " busy_len"}, busy_len, NBYTES * 100);
    check({name, " frame_id"}, fid, fexp);
    check({name, " framing"}, rx_ferr, 0);
    rxq.delete();
    rxt.delete();
  endtask

  task automatic main_seq();
    vec_t vt [4];
    pts_t p0;
    int   n, n2, low0;

    vt[0].p = '0; vt[0].p[0] = 16'h0140; vt[0].p[1] = 16'h00F0; vt[0].csum = 8'h32;
    vt[1].p = '1; vt[1].csum = 8'hF2;
    vt[2].p = '0; vt[2].p[0] = 16'h1234; vt[2].p[1] = 16'h5678;
    vt[2].p[2] = 16'h9ABC; vt[2].p[3] = 16'hDEF0; vt[2].csum = 8'h3B;
    vt[3].p = '0; vt[3].p[6] = 16'h0001; vt[3].p[7] = 16'h8000; vt[3].csum = 8'h85;
    p0 = vt[0].p;

    #1 rst_n = 1'b0;
    #20;
    check("rst tx", tx, 1);
    check("rst busy", busy, 0);
    check("rst frame_id", fid, 0);
    check("rst drop", drop, 0);
    @(posedge clk); #1 rst_n = 1'b1; en = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check("idle txlow", txlow, 0);
    check("idle busy_len", busy_len, 0);
    check("idle rx", rxq.size(), 0);

    for (int i = 0; i < 4; i++) begin
      pts = vt[i].p;
      vs_rise(n);
      repeat (5) @(posedge clk); #1;
      pts = ~vt[i].p;
      vs  = 1'b0;
      wait_idle($sformatf("vec%0d", i));
      check_pkt($sformatf("vec%0d", i), vt[i].p, 8'(i + 1), vt[i].csum, n);
      check($sformatf("vec%0d drop", i), drop, 0);
    end

    // Overrun: second edge lands mid-packet with different points presented.
    pts = p0;
    vs_rise(n);
    repeat (5) @(posedge clk); #1;
    pts = ~p0; vs = 1'b0;
    repeat (495) @(posedge clk); #1;
    vs = 1'b1;
    repeat (5) @(posedge clk); #1;
    vs = 1'b0;
    check("overrun drop", drop, 1);
    wait_idle("overrun");
    check_pkt("overrun", p0, 8'd5, 8'h36, n);
    pts = p0;
    vs_rise(n);
    repeat (5) @(posedge clk); #1;
    vs = 1'b0;
    wait_idle("after_overrun");
    check_pkt("after_overrun", p0, 8'd6, 8'h37, n);
    check("after_overrun drop", drop, 1);

    en   = 1'b0;
    low0 = txlow;
    for (int i = 0; i < 3; i++) begin
      vs_rise(n2);
      repeat (5) @(posedge clk); #1;
      vs = 1'b0;
      repeat (10) @(posedge clk);
    end
    repeat (200) @(posedge clk); #1;
    check("en0 txlow", txlow, low0);
    check("en0 frame_id", fid, 6);
    check("en0 drop", drop, 1);
    check("en0 rx", rxq.size(), 0);

    en = 1'b1;
    vs_rise(n);
    repeat (5) @(posedge clk); #1;
    vs = 1'b0;
    repeat (295) @(posedge clk); #1;
    en = 1'b0;
    wait_idle("en_drop");
    check_pkt("en_drop", p0, 8'd7, 8'h38, n);
    en = 1'b1;

    // Reset in the middle of byte 6 (0x00, so the line is low just before).
    vs_rise(n);
    repeat (5) @(posedge clk); #1;
    vs = 1'b0;
    repeat (647) @(posedge clk); #1;
    check("pre_rst tx", tx, 0);
    rst_n = 1'b0;
    #2;
    check("midrst tx", tx, 1);
    check("midrst busy", busy, 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    check("postrst frame_id", fid, 0);
    check("postrst drop", drop, 0);
    repeat (200) @(posedge clk);
    rxq.delete();
    rxt.delete();
    vs_rise(n);
    repeat (5) @(posedge clk); #1;
    vs = 1'b0;
    wait_idle("post_rst");
    check_pkt("post_rst", p0, 8'd1, 8'h32, n);
  endtask

  task automatic wrap_seq();
    logic [7:0] b;
    wpts = '0;
    wpts[0] = 16'h0140;
    #1 frst_n = 1'b0;
    repeat (3) @(negedge fclk);
    frst_n = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(negedge fclk);
      fvs = 1'b1;
      if (k == 256) begin
        b = '0;
        for (int m = 1; m <= 40; m++) begin
          @(negedge fclk);
          if (m == 2) fvs = 1'b0;
          if (m == 22) check("wrap start1", ftx, 0);
          if (m >= 24 && m <= 38 && ((m - 24) % 2) == 0) b[(m - 24) / 2] = ftx;
        end
        check("wrap byte1", b, 8'h00);
      end else begin
        @(negedge fclk);
        fvs = 1'b0;
      end
      repeat (400) @(negedge fclk);
      if (k == 1)   check("wrap fid1", ffid, 1);
      if (k == 255) check("wrap fid255", ffid, 255);
    end
    check("wrap fid0", ffid, 0);
    check("wrap drop", fdrop, 0);
    check("wrap busy", fbusy, 0);
  endtask

  initial begin
    fork
      main_seq();
      wrap_seq();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

endmodule
